// File: rtl/mem_wb_stage_if.sv
// Data-memory request/response bus between mem_wb_stage and the data cache.
// The stage is the master; the memory answers with data_resp/data_rdata.
interface mem_wb_stage_if;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_addr;
  logic [3:0]  data_mbe;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_resp;

  modport master (
    output data_read, data_write, data_addr,
    output data_mbe, data_wdata,
    input  data_rdata, data_resp
  );

  modport slave (
    input  data_read, data_write, data_addr,
    input  data_mbe, data_wdata,
    output data_rdata, data_resp
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory + writeback stage of the rv32i pipeline.
// Issues one data access at a time and produces the regfile write bus.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [2:0]    ex_funct3,
  input  logic          ex_mem_read,
  input  logic          ex_mem_write,
  input  logic          ex_load_regfile,
  input  logic [4:0]    ex_rd,
  input  logic [2:0]    ex_wb_sel,
  input  logic [31:0]   ex_alu_out,
  input  logic          ex_br_en,
  input  logic [31:0]   ex_u_imm,
  input  logic [31:0]   ex_pc,
  input  logic [31:0]   ex_rs2_out,
  mem_wb_stage_if.master dmem,
  output logic [4:0]    rd_wb,
  output logic          load_regfile_wb,
  output logic [31:0]   regfilemux_out_wb,
  output logic          misalign_err,
  output logic          timeout_err
);

  typedef enum logic {IDLE, MEM} state_e;

  typedef struct packed {
    logic [2:0] funct3;
    logic       is_load;
    logic       lrf;
    logic [4:0] rd;
    logic [1:0] off;
  } mem_req_t;

  state_e      state_q, state_d;
  mem_req_t    req_q, req_d;
  logic [31:0] cnt_q, cnt_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  mbe_q, mbe_d;
  logic [31:0] wdat_q, wdat_d;
  logic [4:0]  rdwb_q, rdwb_d;
  logic        lrf_q, lrf_d;
  logic [31:0] wbv_q, wbv_d;
  logic        mis_q, mis_d;
  logic        tmo_q, tmo_d;

  logic        is_mem, misal;
  logic [31:0] wb_val, ld_sh, ld_val;
  logic [3:0]  st_mbe;
  logic [31:0] st_wdat;

  assign ex_ready = (state_q == IDLE);
  assign is_mem   = ex_mem_read | ex_mem_write;
  assign misal    = ((ex_funct3[1:0] == 2'b10)
                     & (ex_alu_out[1:0] != 2'b00))
                  | ((ex_funct3[1:0] == 2'b01)
                     & ex_alu_out[0]);

  always_comb begin
    wb_val = ex_alu_out;
    unique case (1'b1)
      (ex_wb_sel == 3'd1): wb_val = {31'b0, ex_br_en};
      (ex_wb_sel == 3'd2): wb_val = ex_u_imm;
      (ex_wb_sel == 3'd3): wb_val = ex_pc + 32'd4;
      default: ;
    endcase
  end

  always_comb begin
    st_mbe  = 4'b1111;
    st_wdat = ex_rs2_out;
    unique case (ex_funct3[1:0])
      2'b00: begin
        st_mbe  = 4'b0001 << ex_alu_out[1:0];
        st_wdat = {4{ex_rs2_out[7:0]}};
      end
      2'b01: begin
        st_mbe  = 4'b0011 << ex_alu_out[1:0];
        st_wdat = {2{ex_rs2_out[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_sh = dmem.data_rdata >> {req_q.off, 3'b000};

  always_comb begin
    ld_val = ld_sh;
    unique case (req_q.funct3)
      3'b000: ld_val = {{24{ld_sh[7]}}, ld_sh[7:0]};
      3'b001: ld_val = {{16{ld_sh[15]}}, ld_sh[15:0]};
      3'b100: ld_val = {24'b0, ld_sh[7:0]};
      3'b101: ld_val = {16'b0, ld_sh[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    mbe_d   = mbe_q;
    wdat_d  = wdat_q;
    rdwb_d  = rdwb_q;
    wbv_d   = wbv_q;
    lrf_d   = 1'b0;
    mis_d   = 1'b0;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (!is_mem) begin
            rdwb_d = ex_rd;
            wbv_d  = wb_val;
            lrf_d  = ex_load_regfile & (ex_rd != 5'd0);
          end else if (misal) begin
            mis_d = 1'b1;
          end else begin
            state_d        = MEM;
            req_d.funct3   = ex_funct3;
            req_d.is_load  = ex_mem_read;
            req_d.lrf      = ex_load_regfile;
            req_d.rd       = ex_rd;
            req_d.off      = ex_alu_out[1:0];
            cnt_d          = 32'd0;
            rd_d           = ex_mem_read;
            wr_d           = ex_mem_write & ~ex_mem_read;
            addr_d         = {ex_alu_out[31:2], 2'b00};
            mbe_d          = ex_mem_read ? 4'b1111 : st_mbe;
            wdat_d         = st_wdat;
          end
        end
      end
      MEM: begin
        if (dmem.data_resp) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (req_q.is_load) begin
            rdwb_d = req_q.rd;
            wbv_d  = ld_val;
            lrf_d  = req_q.lrf & (req_q.rd != 5'd0);
          end
        end else if ((TIMEOUT_CYCLES != 0)
                     && (cnt_q == TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      mbe_q   <= '0;
      wdat_q  <= '0;
      rdwb_q  <= '0;
      lrf_q   <= 1'b0;
      wbv_q   <= '0;
      mis_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      mbe_q   <= mbe_d;
      wdat_q  <= wdat_d;
      rdwb_q  <= rdwb_d;
      lrf_q   <= lrf_d;
      wbv_q   <= wbv_d;
      mis_q   <= mis_d;
      tmo_q   <= tmo_d;
    end
  end

  assign dmem.data_read     = rd_q;
  assign dmem.data_write    = wr_q;
  assign dmem.data_addr     = addr_q;
  assign dmem.data_mbe      = mbe_q;
  assign dmem.data_wdata    = wdat_q;
  assign rd_wb              = rdwb_q;
  assign load_regfile_wb    = lrf_q;
  assign regfilemux_out_wb  = wbv_q;
  assign misalign_err       = mis_q;
  assign timeout_err        = tmo_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: vector table, memory responder, event scoreboard.
// Writebacks and error pulses are matched in order against expected events.
module tb_mem_wb_stage;

  localparam int EV_NONE = 0;
  localparam int EV_WB   = 1;
  localparam int EV_MIS  = 2;
  localparam int EV_TMO  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [2:0]  ex_funct3 = '0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic        ex_load_regfile = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic [2:0]  ex_wb_sel = '0;
  logic [31:0] ex_alu_out = '0;
  logic        ex_br_en = 1'b0;
  logic [31:0] ex_u_imm = '0;
  logic [31:0] ex_pc = '0;
  logic [31:0] ex_rs2_out = '0;
  logic [4:0]  rd_wb;
  logic        load_regfile_wb;
  logic [31:0] regfilemux_out_wb;
  logic        misalign_err;
  logic        timeout_err;

  mem_wb_stage_if dmem ();

  mem_wb_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_funct3(ex_funct3),
    .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write),
    .ex_load_regfile(ex_load_regfile),
    .ex_rd(ex_rd), .ex_wb_sel(ex_wb_sel),
    .ex_alu_out(ex_alu_out), .ex_br_en(ex_br_en),
    .ex_u_imm(ex_u_imm), .ex_pc(ex_pc),
    .ex_rs2_out(ex_rs2_out),
    .dmem(dmem),
    .rd_wb(rd_wb),
    .load_regfile_wb(load_regfile_wb),
    .regfilemux_out_wb(regfilemux_out_wb),
    .misalign_err(misalign_err),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic        mr, mw, lrf;
    logic [4:0]  rd;
    logic [2:0]  sel;
    logic [31:0] alu;
    logic        br;
    logic [31:0] uimm, pc, rs2, rdata;
    int          k;
    int          kind;
    logic [31:0] val;
    logic [3:0]  mbe;
    logic [31:0] wdata;
  } vec_t;

  typedef struct {
    int          kind;
    logic [4:0]  rd;
    logic [31:0] val;
  } ev_t;

  vec_t vecs[18];
  ev_t  sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (load_regfile_wb || misalign_err
                 || timeout_err)) begin
      ev_t a, e;
      a.kind = load_regfile_wb ? EV_WB
             : misalign_err ? EV_MIS : EV_TMO;
      a.rd  = rd_wb;
      a.val = regfilemux_out_wb;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: got kind %0d rd %0d val %h want none",
                 a.kind, a.rd, a.val);
      end else begin
        e = sb.pop_front();
        check("ev_kind", a.kind, e.kind);
        if (e.kind == EV_WB) begin
          check("ev_rd", {27'b0, a.rd}, {27'b0, e.rd});
          check("ev_val", a.val, e.val);
        end
      end
    end
  end

  task automatic drive(vec_t v);
    ex_valid        = 1'b1;
    ex_funct3       = v.f3;
    ex_mem_read     = v.mr;
    ex_mem_write    = v.mw;
    ex_load_regfile = v.lrf;
    ex_rd           = v.rd;
    ex_wb_sel       = v.sel;
    ex_alu_out      = v.alu;
    ex_br_en        = v.br;
    ex_u_imm        = v.uimm;
    ex_pc           = v.pc;
    ex_rs2_out      = v.rs2;
  endtask

  task automatic run_vec(vec_t v);
    ev_t e;
    logic [31:0] wa;
    wa = {v.alu[31:2], 2'b00};
    check({v.name, "_ready_in"}, {31'b0, ex_ready}, 32'd1);
    drive(v);
    if (v.kind != EV_NONE) begin
      e.kind = v.kind; e.rd = v.rd; e.val = v.val;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    ex_valid = 1'b0;
    if (!(v.mr || v.mw)) return;
    if (v.kind == EV_MIS) begin
      check({v.name, "_mis_rd"}, {31'b0, dmem.data_read}, 32'd0);
      check({v.name, "_mis_wr"}, {31'b0, dmem.data_write}, 32'd0);
      check({v.name, "_mis_rdy"}, {31'b0, ex_ready}, 32'd1);
      return;
    end
    check({v.name, "_req_rd"}, {31'b0, dmem.data_read}, {31'b0, v.mr});
    check({v.name, "_req_wr"}, {31'b0, dmem.data_write}, {31'b0, v.mw});
    check({v.name, "_addr"}, dmem.data_addr, wa);
    check({v.name, "_mbe"}, {28'b0, dmem.data_mbe}, {28'b0, v.mbe});
    if (v.mw) check({v.name, "_wdata"}, dmem.data_wdata, v.wdata);
    check({v.name, "_busy"}, {31'b0, ex_ready}, 32'd0);
    if (v.k == 0) begin
      repeat (3) @(posedge clk);
      #1;
      check({v.name, "_still"}, {31'b0, dmem.data_read}, 32'd1);
      @(posedge clk); #1;
    end else begin
      repeat (v.k - 1) @(posedge clk);
      if (v.k > 1) #1;
      check({v.name, "_stable"}, dmem.data_addr, wa);
      dmem.data_resp  = 1'b1;
      dmem.data_rdata = v.rdata;
      @(posedge clk); #1;
      dmem.data_resp  = 1'b0;
      dmem.data_rdata = 32'hDEAD_DEAD;
    end
    check({v.name, "_done_rd"}, {31'b0, dmem.data_read}, 32'd0);
    check({v.name, "_done_wr"}, {31'b0, dmem.data_write}, 32'd0);
    check({v.name, "_done_rdy"}, {31'b0, ex_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ev_t e;
    vecs[0]  = '{"addi", 3'd0, 0,0,1, 5'd5, 3'd0, 32'h11, 0, 0, 0, 0, 0, 0, EV_WB, 32'h11, 0, 0};
    vecs[1]  = '{"slt", 3'd2, 0,0,1, 5'd6, 3'd1, 32'h0, 1, 0, 0, 0, 0, 0, EV_WB, 32'h1, 0, 0};
    vecs[2]  = '{"lui", 3'd0, 0,0,1, 5'd7, 3'd2, 32'h55, 0, 32'hDEADB000, 0, 0, 0, 0, EV_WB, 32'hDEADB000, 0, 0};
    vecs[3]  = '{"jal", 3'd0, 0,0,1, 5'd1, 3'd3, 32'h0, 0, 0, 32'hFFFFFFFC, 0, 0, 0, EV_WB, 32'h0, 0, 0};
    vecs[4]  = '{"rd0", 3'd0, 0,0,1, 5'd0, 3'd0, 32'h99, 0, 0, 0, 0, 0, 0, EV_NONE, 0, 0, 0};
    vecs[5]  = '{"nolrf", 3'd0, 0,0,0, 5'd8, 3'd0, 32'h77, 0, 0, 0, 0, 0, 0, EV_NONE, 0, 0, 0};
    vecs[6]  = '{"lb", 3'd0, 1,0,1, 5'd9, 3'd4, 32'h1003, 0, 0, 0, 0, 32'h80FFFF00, 3, EV_WB, 32'hFFFFFF80, 4'hF, 0};
    vecs[7]  = '{"lbu", 3'd4, 1,0,1, 5'd10, 3'd4, 32'h1001, 0, 0, 0, 0, 32'h12348000, 1, EV_WB, 32'h80, 4'hF, 0};
    vecs[8]  = '{"lh", 3'd1, 1,0,1, 5'd11, 3'd4, 32'h1002, 0, 0, 0, 0, 32'h80010000, 2, EV_WB, 32'hFFFF8001, 4'hF, 0};
    vecs[9]  = '{"lhu", 3'd5, 1,0,1, 5'd12, 3'd4, 32'h1000, 0, 0, 0, 0, 32'h0000F00D, 1, EV_WB, 32'hF00D, 4'hF, 0};
    vecs[10] = '{"lw", 3'd2, 1,0,1, 5'd13, 3'd4, 32'h1004, 0, 0, 0, 0, 32'hCAFEBABE, 2, EV_WB, 32'hCAFEBABE, 4'hF, 0};
    vecs[11] = '{"sh", 3'd1, 0,1,0, 5'd0, 3'd0, 32'h2002, 0, 0, 0, 32'h1234ABCD, 0, 2, EV_NONE, 0, 4'hC, 32'hABCDABCD};
    vecs[12] = '{"sb", 3'd0, 0,1,1, 5'd4, 3'd0, 32'h2001, 0, 0, 0, 32'h000000A5, 0, 1, EV_NONE, 0, 4'h2, 32'hA5A5A5A5};
    vecs[13] = '{"sw", 3'd2, 0,1,0, 5'd0, 3'd0, 32'h2008, 0, 0, 0, 32'h01020304, 0, 1, EV_NONE, 0, 4'hF, 32'h01020304};
    vecs[14] = '{"lw_mis", 3'd2, 1,0,1, 5'd3, 3'd4, 32'h3001, 0, 0, 0, 0, 0, 0, EV_MIS, 0, 0, 0};
    vecs[15] = '{"sh_mis", 3'd1, 0,1,0, 5'd0, 3'd0, 32'h3003, 0, 0, 0, 32'h5555, 0, 0, EV_MIS, 0, 0, 0};
    vecs[16] = '{"lw_tmo", 3'd2, 1,0,1, 5'd14, 3'd4, 32'h4000, 0, 0, 0, 0, 0, 0, EV_TMO, 0, 4'hF, 0};
    vecs[17] = '{"lb_k4", 3'd0, 1,0,1, 5'd15, 3'd4, 32'h1000, 0, 0, 0, 0, 32'h0000007F, 4, EV_WB, 32'h7F, 4'hF, 0};

    dmem.data_resp  = 1'b0;
    dmem.data_rdata = 32'hDEAD_DEAD;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, ex_ready}, 32'd1);
    check("rst_read", {31'b0, dmem.data_read}, 32'd0);
    check("rst_write", {31'b0, dmem.data_write}, 32'd0);
    check("rst_addr", dmem.data_addr, 32'd0);
    check("rst_mbe", {28'b0, dmem.data_mbe}, 32'd0);
    check("rst_wdata", dmem.data_wdata, 32'd0);
    check("rst_rdwb", {27'b0, rd_wb}, 32'd0);
    check("rst_strobe", {31'b0, load_regfile_wb}, 32'd0);
    check("rst_wbval", regfilemux_out_wb, 32'd0);
    check("rst_errs", {30'b0, misalign_err, timeout_err}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) run_vec(vecs[i]);

    // lbu to x0 with an addi held behind it while the stage is busy
    drive('{"lbu0", 3'd4, 1,0,1, 5'd0, 3'd4, 32'h1000, 0, 0, 0, 0, 0, 0, EV_NONE, 0, 0, 0});
    @(posedge clk); #1;
    drive('{"addi2", 3'd0, 0,0,1, 5'd2, 3'd0, 32'h2A, 0, 0, 0, 0, 0, 0, EV_WB, 0, 0, 0});
    e.kind = EV_WB; e.rd = 5'd2; e.val = 32'h2A;
    sb.push_back(e);
    check("b2b_busy", {31'b0, ex_ready}, 32'd0);
    dmem.data_resp  = 1'b1;
    dmem.data_rdata = 32'h000000FF;
    @(posedge clk); #1;
    dmem.data_resp = 1'b0;
    check("b2b_nostrobe", {31'b0, load_regfile_wb}, 32'd0);
    check("b2b_ready", {31'b0, ex_ready}, 32'd1);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    check("b2b_strobe", {31'b0, load_regfile_wb}, 32'd1);
    @(posedge clk); #1;
    check("b2b_once", {31'b0, load_regfile_wb}, 32'd0);

    // reset while a load is outstanding, then a stray response
    drive('{"lw_rst", 3'd2, 1,0,1, 5'd16, 3'd4, 32'h5000, 0, 0, 0, 0, 0, 0, EV_NONE, 0, 0, 0});
    @(posedge clk); #1;
    ex_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rstm_pending", {31'b0, dmem.data_read}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstm_read", {31'b0, dmem.data_read}, 32'd0);
    check("rstm_addr", dmem.data_addr, 32'd0);
    check("rstm_ready", {31'b0, ex_ready}, 32'd1);
    dmem.data_resp  = 1'b1;
    dmem.data_rdata = 32'h12345678;
    @(posedge clk); #1;
    dmem.data_resp = 1'b0;
    @(posedge clk); #1;
    check("idle_resp_strobe", {31'b0, load_regfile_wb}, 32'd0);
    check("idle_resp_ready", {31'b0, ex_ready}, 32'd1);

    repeat (3) @(posedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
